// File: rtl/led_seq_pkg.sv
// Shared constants and types for the LED PIO write sequencer.
// Register map, CTRL bit positions, grant and arbiter state encodings.
package led_seq_pkg;

    localparam logic [1:0] ADDR_LED      = 2'd0;
    localparam logic [1:0] ADDR_CTRL     = 2'd1;
    localparam logic [1:0] ADDR_PRESCALE = 2'd2;
    localparam logic [1:0] ADDR_COUNT    = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_DOWN = 1;
    localparam int CTRL_OVR  = 8;

    typedef enum logic {
        GNT_CPU,
        GNT_CNT
    } grant_e;

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } arb_state_e;

endpackage

// File: rtl/led_pio_sequencer_prescaler.sv
// Reloading down-counter producing a one-cycle tick every PRESCALE+1 clocks.
// Holds at the reload value while disabled.
module led_prescaler #(
    parameter int          DIV_W     = 26,
    parameter int unsigned DIV_RESET = 49_999_999
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] prescale_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] load_val_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] pcnt_q;
    logic [DIV_W-1:0] pcnt_d;

    assign tick_o = en_i && (pcnt_q == '0);

    always_comb begin
        pcnt_d = pcnt_q;
        if (load_i) begin
            pcnt_d = load_val_i;
        end else if (!en_i || pcnt_q == '0) begin
            pcnt_d = prescale_i;
        end else begin
            pcnt_d = pcnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pcnt_q <= DIV_W'(DIV_RESET);
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/led_pio_sequencer.sv
// Owns the LED PIO write port, sharing it round-robin between forwarded
// CPU writes and a prescaled up/down counter display.
module led_pio_sequencer
    import led_seq_pkg::*;
#(
    parameter int          DATA_W    = 9,
    parameter int          DIV_W     = 26,
    parameter int unsigned DIV_RESET = 49_999_999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        s_address,
    input  logic              s_chipselect,
    input  logic              s_write_n,
    input  logic              s_read_n,
    input  logic [31:0]       s_writedata,
    output logic [31:0]       s_readdata,
    output logic              s_waitrequest,
    output logic [1:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [DATA_W-1:0] m_writedata,
    output logic [DATA_W-1:0] count_value,
    output logic              tick
);

    logic              en_q, down_q, ovr_q, ovr_d;
    logic [DIV_W-1:0]  prescale_q;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic              cnt_pend_q, cnt_pend_d;
    logic              cpu_pend_q, cpu_pend_d;
    logic [DATA_W-1:0] cpu_buf_q;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    grant_e            last_q, last_d;
    arb_state_e        state_q, state_d;
    logic              gnt_cpu, gnt_cnt;
    logic [31:0]       rd_mux, readdata_q;
    logic              wr_en, rd_en;
    logic              cpu_acc, cnt_load, pre_load, ctrl_wr;
    logic              unused_wdata;

    assign unused_wdata = ^s_writedata[31:DIV_W];

    assign wr_en    = s_chipselect & ~s_write_n;
    assign rd_en    = s_chipselect & ~s_read_n;
    assign cpu_acc  = wr_en & (s_address == ADDR_LED) & ~cpu_pend_q;
    assign cnt_load = wr_en & (s_address == ADDR_COUNT);
    assign pre_load = wr_en & (s_address == ADDR_PRESCALE);
    assign ctrl_wr  = wr_en & (s_address == ADDR_CTRL);

    assign s_waitrequest = wr_en & (s_address == ADDR_LED) & cpu_pend_q;
    assign s_readdata    = readdata_q;
    assign m_address     = 2'b00;
    assign m_chipselect  = (state_q == S_WRITE);
    assign m_write_n     = ~(state_q == S_WRITE);
    assign m_writedata   = shadow_q;
    assign count_value   = cnt_q;

    led_prescaler #(
        .DIV_W     (DIV_W),
        .DIV_RESET (DIV_RESET)
    ) u_prescaler (
        .clk_i      (clk),
        .reset_i    (reset),
        .en_i       (en_q),
        .prescale_i (prescale_q),
        .load_i     (pre_load),
        .load_val_i (s_writedata[DIV_W-1:0]),
        .tick_o     (tick)
    );

    // last_grant only moves on contention, so ties alternate
    always_comb begin
        gnt_cpu  = cpu_pend_q;
        gnt_cnt  = cnt_pend_q;
        last_d   = last_q;
        if (cpu_pend_q && cnt_pend_q) begin
            gnt_cpu = (last_q == GNT_CNT);
            gnt_cnt = (last_q == GNT_CPU);
            last_d  = gnt_cpu ? GNT_CPU : GNT_CNT;
        end
        state_d  = (gnt_cpu || gnt_cnt) ? S_WRITE : S_IDLE;
        shadow_d = shadow_q;
        if (gnt_cpu) begin
            shadow_d = cpu_buf_q;
        end else if (gnt_cnt) begin
            shadow_d = cnt_q;
        end
        cpu_pend_d = (cpu_pend_q & ~gnt_cpu) | cpu_acc;
    end

    always_comb begin
        cnt_d      = cnt_q;
        cnt_pend_d = cnt_pend_q & ~gnt_cnt;
        ovr_d      = ovr_q;
        if (ctrl_wr && s_writedata[CTRL_OVR]) begin
            ovr_d = 1'b0;
        end
        if (cnt_load) begin
            cnt_d      = s_writedata[DATA_W-1:0];
            cnt_pend_d = 1'b1;
        end else if (tick) begin
            cnt_d      = down_q ? cnt_q - DATA_W'(1) : cnt_q + DATA_W'(1);
            cnt_pend_d = 1'b1;
            if (cnt_pend_q && !gnt_cnt) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (s_address)
            ADDR_LED:      rd_mux[DATA_W-1:0] = shadow_q;
            ADDR_CTRL: begin
                rd_mux[CTRL_EN]   = en_q;
                rd_mux[CTRL_DOWN] = down_q;
                rd_mux[CTRL_OVR]  = ovr_q;
            end
            ADDR_PRESCALE: rd_mux[DIV_W-1:0] = prescale_q;
            ADDR_COUNT:    rd_mux[DATA_W-1:0] = cnt_q;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= 1'b0;
            down_q     <= 1'b0;
            ovr_q      <= 1'b0;
            prescale_q <= DIV_W'(DIV_RESET);
            cnt_q      <= '0;
            cnt_pend_q <= 1'b0;
            cpu_pend_q <= 1'b0;
            cpu_buf_q  <= '0;
            shadow_q   <= '0;
            last_q     <= GNT_CNT;
            state_q    <= S_IDLE;
            readdata_q <= '0;
        end else begin
            if (ctrl_wr) begin
                en_q   <= s_writedata[CTRL_EN];
                down_q <= s_writedata[CTRL_DOWN];
            end
            if (pre_load) begin
                prescale_q <= s_writedata[DIV_W-1:0];
            end
            if (cpu_acc) begin
                cpu_buf_q <= s_writedata[DATA_W-1:0];
            end
            ovr_q      <= ovr_d;
            cnt_q      <= cnt_d;
            cnt_pend_q <= cnt_pend_d;
            cpu_pend_q <= cpu_pend_d;
            shadow_q   <= shadow_d;
            last_q     <= last_d;
            state_q    <= state_d;
            readdata_q <= rd_en ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Directed self-checking bench for led_pio_sequencer.
module tb_led_pio_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  s_address = 2'd0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic        s_read_n = 1'b1;
    logic [31:0] s_writedata = 32'd0;
    logic [31:0] s_readdata;
    logic        s_waitrequest;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [8:0]  m_writedata;
    logic [8:0]  count_value;
    logic        tick;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [8:0] sdata[$];
    int         scyc[$];

    led_pio_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .s_address     (s_address),
        .s_chipselect  (s_chipselect),
        .s_write_n     (s_write_n),
        .s_read_n      (s_read_n),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .s_waitrequest (s_waitrequest),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write_n     (m_write_n),
        .m_writedata   (m_writedata),
        .count_value   (count_value),
        .tick          (tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_chipselect && !m_write_n) begin
            sdata.push_back(m_writedata);
            scyc.push_back(cyc);
        end
    end

    task automatic drive(input logic cs, input logic wn, input logic rn,
                         input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        s_chipselect = cs;
        s_write_n    = wn;
        s_read_n     = rn;
        s_address    = a;
        s_writedata  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b1, 1'b1, 2'd0, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        int n;
        n = 0;
        drive(1'b1, 1'b0, 1'b1, a, d);
        #1;
        while (s_waitrequest && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL wr_timeout addr=%0d got waitrequest stuck want release", a);
        end
        idle(1);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        drive(1'b1, 1'b1, 1'b0, a, 32'd0);
        @(negedge clk);
        d = s_readdata;
        s_chipselect = 1'b0;
        s_read_n     = 1'b1;
    endtask

    task automatic clear_q();
        @(negedge clk);
        #2;
        sdata.delete();
        scyc.delete();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (m_write_n !== 1'b1 || m_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL rst_strobe got cs=%b wn=%b want cs=0 wn=1", m_chipselect, m_write_n);
        end
        checks++;
        if (m_writedata !== 9'd0 || m_address !== 2'd0) begin
            errors++;
            $display("FAIL rst_mdata got %h/%h want 0/0", m_writedata, m_address);
        end
        checks++;
        if (tick !== 1'b0 || count_value !== 9'd0 || s_readdata !== 32'd0) begin
            errors++;
            $display("FAIL rst_outs got tick=%b cnt=%h rd=%h want 0", tick, count_value, s_readdata);
        end
        reset = 1'b0;
        rd(2'd2, d);
        checks++;
        if (d !== 32'd49_999_999) begin
            errors++;
            $display("FAIL rst_prescale got %0d want 49999999", d);
        end
        rd(2'd1, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rst_ctrl got %h want 0", d);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rst_led got %h want 0", d);
        end
    endtask

    task automatic test_count_up();
        wr(2'd2, 32'd3);
        wr(2'd3, 32'h1FE);
        idle(4);
        clear_q();
        wr(2'd1, 32'd1);
        idle(16);
        wr(2'd1, 32'd0);
        idle(4);
        checks++;
        if (sdata.size() < 3) begin
            errors++;
            $display("FAIL up_count got %0d strobes want >=3", sdata.size());
        end else begin
            checks++;
            if (sdata[0] !== 9'h1FF) begin
                errors++;
                $display("FAIL up_v0 got %h want 1ff", sdata[0]);
            end
            checks++;
            if (sdata[1] !== 9'h000) begin
                errors++;
                $display("FAIL up_wrap got %h want 000", sdata[1]);
            end
            checks++;
            if (sdata[2] !== 9'h001) begin
                errors++;
                $display("FAIL up_v2 got %h want 001", sdata[2]);
            end
            checks++;
            if (scyc[1] - scyc[0] != 4 || scyc[2] - scyc[1] != 4) begin
                errors++;
                $display("FAIL up_period got %0d,%0d want 4,4",
                         scyc[1] - scyc[0], scyc[2] - scyc[1]);
            end
        end
    endtask

    task automatic test_cpu_forward();
        logic [31:0] d;
        drive(1'b1, 1'b0, 1'b1, 2'd0, 32'h0AA);
        #1;
        checks++;
        if (s_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL fwd_wait0 got %b want 0", s_waitrequest);
        end
        @(negedge clk);
        s_writedata = 32'h055;
        #1;
        checks++;
        if (s_waitrequest !== 1'b1 || m_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL fwd_c1 got wait=%b cs=%b want 1/0", s_waitrequest, m_chipselect);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || m_writedata !== 9'h0AA) begin
            errors++;
            $display("FAIL fwd_c2 got cs=%b data=%h want 1/0aa", m_chipselect, m_writedata);
        end
        checks++;
        if (s_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL fwd_wait2 got %b want 0", s_waitrequest);
        end
        @(negedge clk);
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
        checks++;
        if (m_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL fwd_c3 got cs=%b want 0", m_chipselect);
        end
        @(negedge clk);
        checks++;
        if (m_chipselect !== 1'b1 || m_writedata !== 9'h055) begin
            errors++;
            $display("FAIL fwd_c4 got cs=%b data=%h want 1/055", m_chipselect, m_writedata);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'h055) begin
            errors++;
            $display("FAIL fwd_shadow got %h want 055", d);
        end
    endtask

    task automatic tie_seq(input logic [8:0] led, input bit do_rst);
        drive(1'b1, 1'b0, 1'b1, 2'd1, 32'd1);
        idle(1);
        drive(1'b1, 1'b0, 1'b1, 2'd0, {23'd0, led});
        if (do_rst) begin
            idle(1);
            reset = 1'b1;
            idle(1);
            idle(1);
            reset = 1'b0;
        end else begin
            drive(1'b1, 1'b0, 1'b1, 2'd1, 32'd0);
        end
        idle(6);
    endtask

    task automatic test_back_to_back();
        wr(2'd2, 32'd1);
        wr(2'd3, 32'h010);
        idle(4);
        clear_q();
        tie_seq(9'h111, 1'b0);
        checks++;
        if (sdata.size() != 2) begin
            errors++;
            $display("FAIL tie1_n got %0d want 2", sdata.size());
        end else begin
            checks++;
            if (sdata[0] !== 9'h111 || sdata[1] !== 9'h011) begin
                errors++;
                $display("FAIL tie1_order got %h,%h want 111,011", sdata[0], sdata[1]);
            end
            checks++;
            if (scyc[1] != scyc[0] + 1) begin
                errors++;
                $display("FAIL tie1_b2b got gap %0d want 1", scyc[1] - scyc[0]);
            end
        end
        clear_q();
        tie_seq(9'h122, 1'b0);
        checks++;
        if (sdata.size() != 2) begin
            errors++;
            $display("FAIL tie2_n got %0d want 2", sdata.size());
        end else begin
            checks++;
            if (sdata[0] !== 9'h012 || sdata[1] !== 9'h122) begin
                errors++;
                $display("FAIL tie2_order got %h,%h want 012,122", sdata[0], sdata[1]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        int n;
        wr(2'd2, 32'd0);
        wr(2'd1, 32'd1);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 1'b1, 2'd0, 32'(i));
        end
        idle(4);
        rd(2'd1, d);
        checks++;
        if (d !== 32'h101) begin
            errors++;
            $display("FAIL ovr_set got %h want 101", d);
        end
        wr(2'd1, 32'h101);
        idle(2);
        rd(2'd1, d);
        checks++;
        if (d !== 32'h001) begin
            errors++;
            $display("FAIL ovr_clr got %h want 001", d);
        end
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd5);
        wr(2'd3, 32'd0);
        idle(4);
        clear_q();
        wr(2'd1, 32'd3);
        n = 0;
        while (sdata.size() == 0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sdata.size() == 0) begin
            errors++;
            $display("FAIL down_timeout got no strobe want 1ff");
        end else if (sdata[0] !== 9'h1FF) begin
            errors++;
            $display("FAIL down_wrap got %h want 1ff", sdata[0]);
        end
        wr(2'd1, 32'd2);
        checks++;
        if (count_value !== 9'h1FF) begin
            errors++;
            $display("FAIL down_cnt got %h want 1ff", count_value);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wr(2'd2, 32'd1);
        idle(4);
        clear_q();
        tie_seq(9'h133, 1'b1);
        checks++;
        if (sdata.size() != 0) begin
            errors++;
            $display("FAIL rstmid_strobe got %0d strobes want 0", sdata.size());
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_shadow got %h want 0", d);
        end
        rd(2'd2, d);
        checks++;
        if (d !== 32'd49_999_999 || count_value !== 9'd0) begin
            errors++;
            $display("FAIL rstmid_regs got pre=%0d cnt=%h want 49999999/0", d, count_value);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_cpu_forward();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
